// File: rtl/uart_rx_fsm.sv
// UART 8N1 receive controller driving an external baud counter (reload + period select).
// Define UART_RX_PARITY_EN to expect one even-parity bit before the stop bit.
module uart_rx_fsm (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       rx_in,
  input  logic       baud_tick,
  output logic       baud_rst,
  output logic       baud_load,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  function automatic logic odd_ones(input logic [7:0] d);
    return ^d;
  endfunction

  state_t     state_r;
  logic [1:0] sync_r;
  logic       rx_s;
  logic [7:0] shift_r;
  logic [2:0] bit_cnt_r;
  logic [7:0] rx_data_r;
  logic       rx_valid_r;
  logic       frame_err_r;
  logic       brk_wait_r;
`ifdef UART_RX_PARITY_EN
  logic       parity_err_r;
  logic       par_bad_r;
`endif

  assign rx_s = sync_r[1];

  // Two-flop synchronizer for the asynchronous serial line, idle high.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], rx_in};
    end
  end

  // Receive FSM with registered byte and strobes.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_r      <= ST_IDLE;
      shift_r      <= 8'h00;
      bit_cnt_r    <= 3'd0;
      rx_data_r    <= 8'h00;
      rx_valid_r   <= 1'b0;
      frame_err_r  <= 1'b0;
      brk_wait_r   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_r <= 1'b0;
      par_bad_r    <= 1'b0;
`endif
    end else begin
      rx_valid_r   <= 1'b0;
      frame_err_r  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_r <= 1'b0;
`endif
      case (state_r)
        ST_IDLE: begin
          // After a break, the line must go high before a new falling edge counts.
          if (brk_wait_r) begin
            if (rx_s) begin
              brk_wait_r <= 1'b0;
            end
          end else if (!rx_s) begin
            state_r <= ST_START;
          end
        end
        ST_START: begin
          if (baud_tick) begin
            if (!rx_s) begin
              bit_cnt_r <= 3'd0;
              state_r   <= ST_DATA;
            end else begin
              state_r <= ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (baud_tick) begin
            shift_r   <= {rx_s, shift_r[7:1]};
            bit_cnt_r <= bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_r <= ST_PARITY;
`else
              state_r <= ST_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (baud_tick) begin
            par_bad_r <= odd_ones(shift_r) ^ rx_s;
            state_r   <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (baud_tick) begin
            state_r <= ST_IDLE;
            if (!rx_s) begin
              frame_err_r <= 1'b1;
              brk_wait_r  <= 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (par_bad_r) begin
              parity_err_r <= 1'b1;
`endif
            end else begin
              rx_data_r  <= shift_r;
              rx_valid_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Hold the baud counter at half-period reload while idle; full periods once framing.
  assign baud_rst  = (state_r == ST_IDLE);
  assign baud_load = (state_r != ST_IDLE);
  assign busy      = (state_r != ST_IDLE);
  assign rx_data   = rx_data_r;
  assign rx_valid  = rx_valid_r;
  assign frame_err = frame_err_r;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_r;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed self-checking bench for uart_rx_fsm with a behavioural baud counter
// (16 clk per bit, 8 clk half period reloaded while baud_rst is held).
module tb_uart_rx_fsm;

  localparam int BIT  = 16;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       rx_in = 1'b1;
  logic       baud_tick;
  logic       baud_rst;
  logic       baud_load;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;
  int n_valid  = 0;
  int n_ferr   = 0;
  int n_perr   = 0;
  logic [7:0] data_q[$];

  logic [4:0] cnt_r;
  logic [4:0] per_r;

  uart_rx_fsm dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .rx_in     (rx_in),
    .baud_tick (baud_tick),
    .baud_rst  (baud_rst),
    .baud_load (baud_load),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Baud counter: period latched at each reload, registered tick.
  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_r     <= 5'd0;
      per_r     <= 5'(HALF);
      baud_tick <= 1'b0;
    end else if (baud_rst) begin
      cnt_r     <= 5'd0;
      per_r     <= baud_load ? 5'(BIT) : 5'(HALF);
      baud_tick <= 1'b0;
    end else if (cnt_r == per_r - 5'd1) begin
      cnt_r     <= 5'd0;
      per_r     <= baud_load ? 5'(BIT) : 5'(HALF);
      baud_tick <= 1'b1;
    end else begin
      cnt_r     <= cnt_r + 5'd1;
      baud_tick <= 1'b0;
    end
  end

  // Strobe monitor: counts every cycle a strobe is high, logs data on rx_valid.
  always @(negedge clk) begin
    if (arst_n) begin
      if (rx_valid) begin
        n_valid <= n_valid + 1;
        data_q.push_back(rx_data);
      end
      if (frame_err)  n_ferr <= n_ferr + 1;
      if (parity_err) n_perr <= n_perr + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx_in = b;
    repeat (BIT) @(posedge clk);
    #1;
  endtask

  // Sends start, 8 data bits LSB first, [parity], stop; optionally checks start latency.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input bit lat);
    if (lat) begin
      rx_in = 1'b0;
      @(posedge clk); @(posedge clk); @(negedge clk);
      check_eq("lat_busy_2", {31'd0, busy}, 32'd0);
      @(posedge clk); @(negedge clk);
      check_eq("lat_busy_3", {31'd0, busy}, 32'd1);
      check_eq("lat_brst", {31'd0, baud_rst}, 32'd0);
      check_eq("lat_bload", {31'd0, baud_load}, 32'd1);
      repeat (BIT - 3) @(posedge clk);
      #1;
    end else begin
      send_bit(1'b0);
    end
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(par);
`else
    if (par !== 1'bx) begin end
`endif
    send_bit(stop);
    rx_in = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, f0, qb;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check_eq("rst_brst", {31'd0, baud_rst}, 32'd1);
    check_eq("rst_bload", {31'd0, baud_load}, 32'd0);
    check_eq("rst_data", {24'd0, rx_data}, 32'h00);
    check_eq("rst_valid", {31'd0, rx_valid}, 32'd0);
    check_eq("rst_ferr", {31'd0, frame_err}, 32'd0);
    check_eq("rst_perr", {31'd0, parity_err}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    arst_n = 1'b1;
    @(posedge clk); #1;

    // Reset asserted mid-frame
    rx_in = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    check_eq("mid_busy", {31'd0, busy}, 32'd1);
    arst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_rst_brst", {31'd0, baud_rst}, 32'd1);
    rx_in = 1'b1;
    repeat (3) @(posedge clk);
    #1 arst_n = 1'b1;
    repeat (4) @(posedge clk); #1;
    check_eq("mid_rst_data", {24'd0, rx_data}, 32'h00);
    check_eq("mid_rst_nostrobe", n_valid + n_ferr, 32'd0);

    // Good frame A5 with start-latency checks; strobe must fall inside the stop bit
    v0 = n_valid; f0 = n_ferr; qb = data_q.size();
    send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
    check_eq("a5_valid_cnt", n_valid - v0, 32'd1);
    check_eq("a5_data", {24'd0, rx_data}, 32'hA5);
    check_eq("a5_strobe_data", (data_q.size() > qb) ? {24'd0, data_q[qb]} : 32'hFFFF, 32'hA5);
    check_eq("a5_ferr", n_ferr - f0, 32'd0);
    repeat (BIT) @(posedge clk); #1;
    check_eq("a5_idle", {31'd0, busy}, 32'd0);

    // Start glitch
    v0 = n_valid; f0 = n_ferr;
    rx_in = 1'b0;
    repeat (4) @(posedge clk); #1;
    rx_in = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("glitch_start", {31'd0, busy}, 32'd1);
    repeat (14) @(posedge clk);
    @(negedge clk);
    check_eq("glitch_idle", {31'd0, busy}, 32'd0);
    check_eq("glitch_nostrobe", (n_valid - v0) + (n_ferr - f0), 32'd0);

    // Stop bit low with data 3C
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (BIT) @(posedge clk); #1;
    check_eq("ferr_cnt", n_ferr - f0, 32'd1);
    check_eq("ferr_valid", n_valid - v0, 32'd0);
    check_eq("ferr_data", {24'd0, rx_data}, 32'hA5);

    // Back-to-back 00 then FF
    v0 = n_valid; qb = data_q.size();
    send_frame(8'h00, 1'b0, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b1, 1'b0);
    repeat (BIT) @(posedge clk); #1;
    check_eq("b2b_cnt", n_valid - v0, 32'd2);
    check_eq("b2b_first", (data_q.size() > qb) ? {24'd0, data_q[qb]} : 32'hFFFF, 32'h00);
    check_eq("b2b_second", (data_q.size() > qb + 1) ? {24'd0, data_q[qb + 1]} : 32'hFFFF, 32'hFF);

    // Break: line held low well past one frame
    v0 = n_valid; f0 = n_ferr;
    rx_in = 1'b0;
    repeat (15 * BIT) @(posedge clk); #1;
    check_eq("brk_busy_low", {31'd0, busy}, 32'd0);
    rx_in = 1'b1;
    repeat (3 * BIT) @(posedge clk); #1;
    check_eq("brk_ferr_once", n_ferr - f0, 32'd1);
    check_eq("brk_valid", n_valid - v0, 32'd0);
    check_eq("brk_data", {24'd0, rx_data}, 32'hFF);
    check_eq("brk_idle", {31'd0, busy}, 32'd0);

`ifdef UART_RX_PARITY_EN
    v0 = n_valid; f0 = n_perr;
    send_frame(8'h01, 1'b0, 1'b1, 1'b0);
    repeat (BIT) @(posedge clk); #1;
    check_eq("par_bad_perr", n_perr - f0, 32'd1);
    check_eq("par_bad_valid", n_valid - v0, 32'd0);
    check_eq("par_bad_data", {24'd0, rx_data}, 32'hFF);
    v0 = n_valid; f0 = n_perr;
    send_frame(8'h01, 1'b1, 1'b1, 1'b0);
    repeat (BIT) @(posedge clk); #1;
    check_eq("par_ok_valid", n_valid - v0, 32'd1);
    check_eq("par_ok_perr", n_perr - f0, 32'd0);
    check_eq("par_ok_data", {24'd0, rx_data}, 32'h01);
`else
    check_eq("perr_never", n_perr, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
